sseg_capture: RTL and testbench

SSEG_CAPTURE -- requirements
Module: sseg_capture

---
 rtl/sseg_capture_if.sv | 9 +
 rtl/sseg_capture.sv | 178 +++++++++++++++++
 tb/tb_sseg_capture.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/sseg_capture_if.sv
// Seven-segment display bus: active-low segments, digit enables and decimal point.
interface sseg_capture_if;
  logic [6:0] seg;
  logic [3:0] an;
  logic       dp;

  modport master (output seg, an, dp);
  modport slave  (input  seg, an, dp);
endinterface

// File: rtl/sseg_capture.sv
// Captures a multiplexed seven-segment display into decoded per-digit hex values.
// Optional macro SSEG_CAP_SYNC_EN adds a 2-flop input synchronizer (+2 cycles latency).
module sseg_capture #(
  parameter int unsigned STABLE_CYC = 4
) (
  input  logic            clk,
  input  logic            rst,
  sseg_capture_if.slave   disp,
  output logic [15:0]     digits,
  output logic [3:0]      dp_cap,
  output logic [3:0]      blank,
  output logic [3:0]      digit_err,
  output logic            frame_valid
);

  localparam logic [11:0] IDLE_SMP = {4'hF, 1'b1, 7'h7F};
  localparam logic [7:0]  CNT_MAX  = 8'(STABLE_CYC - 1);
  localparam logic [7:0]  CNT_HIT  = 8'(STABLE_CYC - 2);

  // Returns {hit, value}; hit=0 for patterns outside the hex table.
  function automatic logic [4:0] seg_decode(input logic [6:0] s);
    case (s)
      7'h40:   seg_decode = 5'h10;
      7'h79:   seg_decode = 5'h11;
      7'h24:   seg_decode = 5'h12;
      7'h30:   seg_decode = 5'h13;
      7'h19:   seg_decode = 5'h14;
      7'h12:   seg_decode = 5'h15;
      7'h02:   seg_decode = 5'h16;
      7'h78:   seg_decode = 5'h17;
      7'h00:   seg_decode = 5'h18;
      7'h10:   seg_decode = 5'h19;
      7'h08:   seg_decode = 5'h1A;
      7'h03:   seg_decode = 5'h1B;
      7'h46:   seg_decode = 5'h1C;
      7'h21:   seg_decode = 5'h1D;
      7'h06:   seg_decode = 5'h1E;
      7'h0E:   seg_decode = 5'h1F;
      default: seg_decode = 5'h00;
    endcase
  endfunction

  logic [11:0] raw_s;
  logic [11:0] sample_s;

  assign raw_s = {disp.an, disp.dp, disp.seg};

`ifdef SSEG_CAP_SYNC_EN
  logic [11:0] sync1_q, sync1_d;
  logic [11:0] sync2_q, sync2_d;

  // Two-stage synchronizer next values.
  always_comb begin
    sync1_d = raw_s;
    sync2_d = sync1_q;
  end

  // Synchronizer flops, idle pattern on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= IDLE_SMP;
      sync2_q <= IDLE_SMP;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign sample_s = sync2_q;
`else
  assign sample_s = raw_s;
`endif

  logic [11:0] prev_q, prev_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [15:0] digits_q, digits_d;
  logic [3:0]  dp_cap_q, dp_cap_d;
  logic [3:0]  blank_q, blank_d;
  logic [3:0]  err_q, err_d;
  logic [3:0]  seen_q, seen_d;
  logic        fv_q, fv_d;

  logic        same_s;
  logic        strobe_s;
  logic        sel_ok_s;
  logic [1:0]  sel_idx_s;
  logic [4:0]  dec_s;
  logic [3:0]  seen_upd_s;

  // Stability counter, digit select, decode and capture update.
  always_comb begin
    prev_d     = sample_s;
    cnt_d      = cnt_q;
    digits_d   = digits_q;
    dp_cap_d   = dp_cap_q;
    blank_d    = blank_q;
    err_d      = err_q;
    seen_d     = seen_q;
    fv_d       = 1'b0;
    sel_ok_s   = 1'b0;
    sel_idx_s  = 2'd0;
    seen_upd_s = seen_q;

    same_s = (sample_s == prev_q);
    if (!same_s) begin
      cnt_d = 8'd0;
    end else if (cnt_q < CNT_MAX) begin
      cnt_d = cnt_q + 8'd1;
    end else begin
      cnt_d = cnt_q;
    end
    strobe_s = same_s && (cnt_q == CNT_HIT);

    case (sample_s[11:8])
      4'hE:    begin sel_ok_s = 1'b1; sel_idx_s = 2'd0; end
      4'hD:    begin sel_ok_s = 1'b1; sel_idx_s = 2'd1; end
      4'hB:    begin sel_ok_s = 1'b1; sel_idx_s = 2'd2; end
      4'h7:    begin sel_ok_s = 1'b1; sel_idx_s = 2'd3; end
      default: begin sel_ok_s = 1'b0; sel_idx_s = 2'd0; end
    endcase

    dec_s = seg_decode(sample_s[6:0]);

    if (strobe_s && sel_ok_s) begin
      dp_cap_d[sel_idx_s] = ~sample_s[7];
      if (dec_s[4]) begin
        digits_d[{sel_idx_s, 2'b00} +: 4] = dec_s[3:0];
        blank_d[sel_idx_s] = 1'b0;
        err_d[sel_idx_s]   = 1'b0;
      end else if (sample_s[6:0] == 7'h7F) begin
        blank_d[sel_idx_s] = 1'b1;
        err_d[sel_idx_s]   = 1'b0;
      end else begin
        blank_d[sel_idx_s] = 1'b0;
        err_d[sel_idx_s]   = 1'b1;
      end
      seen_upd_s = seen_q | (4'b0001 << sel_idx_s);
      if (seen_upd_s == 4'hF) begin
        fv_d   = 1'b1;
        seen_d = 4'h0;
      end else begin
        seen_d = seen_upd_s;
      end
    end else begin
      seen_d = seen_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q   <= IDLE_SMP;
      cnt_q    <= 8'd0;
      digits_q <= 16'h0000;
      dp_cap_q <= 4'h0;
      blank_q  <= 4'h0;
      err_q    <= 4'h0;
      seen_q   <= 4'h0;
      fv_q     <= 1'b0;
    end else begin
      prev_q   <= prev_d;
      cnt_q    <= cnt_d;
      digits_q <= digits_d;
      dp_cap_q <= dp_cap_d;
      blank_q  <= blank_d;
      err_q    <= err_d;
      seen_q   <= seen_d;
      fv_q     <= fv_d;
    end
  end

  assign digits      = digits_q;
  assign dp_cap      = dp_cap_q;
  assign blank       = blank_q;
  assign digit_err   = err_q;
  assign frame_valid = fv_q;

endmodule

// File: tb/tb_sseg_capture.sv
// Randomized self-checking bench for sseg_capture against a run-length reference model.
module tb_sseg_capture;
  localparam int S = 4;
  localparam logic [11:0] IDLE_SMP = {4'hF, 1'b1, 7'h7F};

  logic clk = 1'b0;
  logic rst;
  logic [15:0] digits;
  logic [3:0]  dp_cap, blank, digit_err;
  logic        frame_valid;

  sseg_capture_if bus();

  sseg_capture #(.STABLE_CYC(S)) dut (
    .clk         (clk),
    .rst         (rst),
    .disp        (bus),
    .digits      (digits),
    .dp_cap      (dp_cap),
    .blank       (blank),
    .digit_err   (digit_err),
    .frame_valid (frame_valid)
  );

  always #5 clk = ~clk;

  logic [6:0] tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                           7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  int n_tests = 0;
  int n_fail  = 0;
  int fv_seen = 0;

  logic [15:0] m_digits;
  logic [3:0]  m_dp, m_blank, m_err, m_seen;
  logic        m_fv;
  logic [11:0] m_last, m_p1, m_p2;
  int          m_run;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: count identical consecutive samples; capture on the S-th one.
  task automatic model_step();
    logic [11:0] s;
    int zeros, idx, val;
    if (rst) begin
      m_digits = 16'h0; m_dp = 4'h0; m_blank = 4'h0; m_err = 4'h0;
      m_seen = 4'h0; m_fv = 1'b0; m_last = IDLE_SMP; m_run = 1;
      m_p1 = IDLE_SMP; m_p2 = IDLE_SMP;
      return;
    end
`ifdef SSEG_CAP_SYNC_EN
    s = m_p2; m_p2 = m_p1; m_p1 = {bus.an, bus.dp, bus.seg};
`else
    s = {bus.an, bus.dp, bus.seg};
`endif
    m_fv = 1'b0;
    if (s == m_last) m_run = (m_run < 1000) ? m_run + 1 : m_run;
    else m_run = 1;
    m_last = s;
    if (m_run == S && (s == m_last)) begin
      zeros = 0; idx = 0;
      for (int i = 0; i < 4; i++) if (s[8+i] == 1'b0) begin zeros++; idx = i; end
      if (zeros == 1) begin
        val = -1;
        for (int k = 0; k < 16; k++) if (tbl[k] == s[6:0]) val = k;
        m_dp[idx] = ~s[7];
        if (val >= 0) begin
          m_digits[idx*4 +: 4] = 4'(val); m_blank[idx] = 1'b0; m_err[idx] = 1'b0;
        end else if (s[6:0] == 7'h7F) begin
          m_blank[idx] = 1'b1; m_err[idx] = 1'b0;
        end else begin
          m_blank[idx] = 1'b0; m_err[idx] = 1'b1;
        end
        m_seen[idx] = 1'b1;
        if (m_seen == 4'hF) begin m_fv = 1'b1; m_seen = 4'h0; end
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    check_eq("digits", 32'(digits), 32'(m_digits));
    check_eq("dp_cap", 32'(dp_cap), 32'(m_dp));
    check_eq("blank", 32'(blank), 32'(m_blank));
    check_eq("digit_err", 32'(digit_err), 32'(m_err));
    check_eq("frame_valid", 32'(frame_valid), 32'(m_fv));
    if (frame_valid) fv_seen++;
  endtask

  task automatic hold(input logic [3:0] an, input logic [6:0] seg, input logic dp, input int n);
    bus.an = an; bus.seg = seg; bus.dp = dp;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    hold(4'hF, 7'h7F, 1'b1, 2);
    rst = 1'b0;
  endtask

  initial begin
    logic [15:0] saved;
    rst = 1'b1; bus.an = 4'hF; bus.seg = 7'h7F; bus.dp = 1'b1;
    do_reset();
    check_eq("rst_digits", 32'(digits), 32'h0);
    check_eq("rst_flags", 32'({dp_cap, blank, digit_err, frame_valid}), 32'h0);

    // Single digit capture.
    hold(4'hE, 7'h24, 1'b1, 3);
    check_eq("r030_before", 32'(digits[3:0]), 32'h0);
    hold(4'hE, 7'h24, 1'b1, 1);
    check_eq("r030_digit", 32'(digits[3:0]), 32'h2);
    check_eq("r030_flags", 32'({dp_cap[0], blank[0], digit_err[0]}), 32'h0);
    hold(4'hE, 7'h24, 1'b1, 6);

    // Full frame scan.
    do_reset();
    fv_seen = 0;
    hold(4'hE, 7'h79, 1'b1, 8);
    hold(4'hD, 7'h24, 1'b1, 8);
    hold(4'hB, 7'h30, 1'b1, 8);
    hold(4'h7, 7'h19, 1'b1, 8);
    check_eq("r031_digits", 32'(digits), 32'h4321);
    check_eq("r031_pulses", 32'(fv_seen), 32'd1);

    // Blank then error on digit 1.
    hold(4'hD, 7'h7F, 1'b1, 10);
    check_eq("r032_blank", 32'(blank[1]), 32'h1);
    check_eq("r032_nibble", 32'(digits[7:4]), 32'h2);
    hold(4'hD, 7'h55, 1'b1, 6);
    check_eq("r032_err", 32'({digit_err[1], blank[1]}), 32'h2);

    // Short dwell rejected, dp captured.
    hold(4'hB, 7'h00, 1'b1, 3);
    check_eq("r033_no8", 32'(digits[11:8]), 32'h3);
    hold(4'hB, 7'h10, 1'b0, 6);
    check_eq("r033_nine", 32'(digits[11:8]), 32'h9);
    check_eq("r033_dp", 32'(dp_cap[2]), 32'h1);

    // Two digits enabled at once.
    saved = digits; fv_seen = 0;
    hold(4'hC, 7'h40, 1'b1, 20);
    check_eq("r034_digits", 32'(digits), 32'(saved));
    check_eq("r034_pulses", 32'(fv_seen), 32'd0);

    // Reset mid-dwell.
    hold(4'hE, 7'h06, 1'b1, 2);
    rst = 1'b1; step(); rst = 1'b0;
    check_eq("r035_rst", 32'({digits, dp_cap, blank, digit_err}), 32'h0);
    hold(4'hE, 7'h06, 1'b1, 3);
    check_eq("r035_early", 32'(digits[3:0]), 32'h0);
    hold(4'hE, 7'h06, 1'b1, 1);
    check_eq("r035_cap", 32'(digits[3:0]), 32'hE);

    // Random dwells.
    for (int t = 0; t < 400; t++) begin
      logic [3:0] an; logic [6:0] seg; logic dp; int r;
      r = $urandom_range(0, 9);
      case (r)
        0:       an = 4'($urandom);
        default: an = ~(4'b0001 << $urandom_range(0, 3));
      endcase
      r = $urandom_range(0, 9);
      if (r < 7) seg = tbl[$urandom_range(0, 15)];
      else if (r == 7) seg = 7'h7F;
      else seg = 7'($urandom);
      dp = 1'($urandom);
      rst = ($urandom_range(0, 49) == 0);
      hold(an, seg, dp, 1);
      rst = 1'b0;
      hold(an, seg, dp, $urandom_range(0, 8));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
